// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and FSM encoding for the data memory responder
package dmem_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // wait-state down-counter width (WAIT_CYCLES up to 15)
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane write mask/replication and load extraction/extension
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // select the addressed byte/half of the read word, then mask/replicate/extend by size
  always_comb begin
    o_wmask = 4'b0000;
    o_wdata = 32'h0;
    o_rdata = 32'h0;
    case (i_addr_lo)
      2'd0:    w_byte = i_rword[7:0];
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      default: w_byte = i_rword[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
    case (i_funct3)
      F3_B: begin
        o_wmask = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_byte[7]}}, w_byte};
      end
      F3_H: begin
        o_wmask = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_half[15]}}, w_half};
      end
      F3_W: begin
        o_wmask = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rword;
      end
      F3_BU:   o_rdata = {24'h0, w_byte};
      F3_HU:   o_rdata = {16'h0, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-stated load/store responder; DMEM_RESP_MISALIGN_TRAP_EN traps misaligned H/W
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [2:0]  i_req_funct3,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_e            r_state;
  state_e            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [2:0]        r_funct3;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic [31:0]       r_mem [0:(1<<ADDR_W)-1];

  logic              w_accept;
  logic              w_cur_we;
  logic [31:0]       w_cur_addr;
  logic [31:0]       w_cur_wdata;
  logic [2:0]        w_cur_funct3;
  logic              w_f3_bad;
  logic              w_range_bad;
  logic              w_mis_bad;
  logic              w_err;
  logic [1:0]        w_addr_lo;
  logic [ADDR_W-1:0] w_word_idx;
  logic              w_enter_resp;
  logic              w_commit;
  logic [3:0]        w_wmask;
  logic [31:0]       w_wdata_rep;
  logic [31:0]       w_rdata_ext;

  assign w_accept = (r_state == ST_IDLE) && i_req_valid;

  // with zero wait states RESP is entered on the accept edge, before the capture registers load
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_cur_we     = i_req_we;
      w_cur_addr   = i_req_addr;
      w_cur_wdata  = i_req_wdata;
      w_cur_funct3 = i_req_funct3;
    end else begin
      w_cur_we     = r_we;
      w_cur_addr   = r_addr;
      w_cur_wdata  = r_wdata;
      w_cur_funct3 = r_funct3;
    end
  end

  // legality of funct3 for the access direction
  always_comb begin
    w_f3_bad = 1'b0;
    if (w_cur_we)
      w_f3_bad = !((w_cur_funct3 == F3_B) || (w_cur_funct3 == F3_H) || (w_cur_funct3 == F3_W));
    else
      w_f3_bad = (w_cur_funct3 == 3'b011) || (w_cur_funct3 == 3'b110) || (w_cur_funct3 == 3'b111);
  end

  assign w_range_bad = |(w_cur_addr >> (ADDR_W + 2));

`ifdef DMEM_RESP_MISALIGN_TRAP_EN
  assign w_mis_bad = (((w_cur_funct3 == F3_H) || (w_cur_funct3 == F3_HU)) && w_cur_addr[0]) ||
                     ((w_cur_funct3 == F3_W) && (w_cur_addr[1:0] != 2'b00));
  assign w_addr_lo = w_cur_addr[1:0];
`else
  assign w_mis_bad = 1'b0;
  // misaligned halves/words silently round down to their natural boundary
  always_comb begin
    w_addr_lo = w_cur_addr[1:0];
    if ((w_cur_funct3 == F3_H) || (w_cur_funct3 == F3_HU))
      w_addr_lo = {w_cur_addr[1], 1'b0};
    else if (w_cur_funct3 == F3_W)
      w_addr_lo = 2'b00;
  end
`endif

  assign w_err        = w_f3_bad || w_range_bad || w_mis_bad;
  assign w_word_idx   = w_cur_addr[ADDR_W+1:2];
  assign w_enter_resp = (r_state != ST_RESP) && (w_next == ST_RESP);
  assign w_commit     = w_enter_resp && w_cur_we && !w_err && !i_rst;

  dmem_lane_align u_lane_align (
    .i_addr_lo (w_addr_lo),
    .i_funct3  (w_cur_funct3),
    .i_wdata   (w_cur_wdata),
    .i_rword   (r_mem[w_word_idx]),
    .o_wmask   (w_wmask),
    .o_wdata   (w_wdata_rep),
    .o_rdata   (w_rdata_ext)
  );

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state: accept, count wait states, hold response until consumed
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == '0) w_next = ST_RESP;
      ST_RESP: if (i_rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // FSM outputs: ready only in IDLE and never while reset is held
  always_comb begin
    o_req_ready = (r_state == ST_IDLE) && !i_rst;
    o_rsp_valid = r_rsp_valid;
    o_rsp_rdata = r_rsp_rdata;
    o_rsp_err   = r_rsp_err;
  end

  // request capture, wait counter and registered response
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we        <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_funct3    <= 3'b000;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= i_req_we;
        r_addr   <= i_req_addr;
        r_wdata  <= i_req_wdata;
        r_funct3 <= i_req_funct3;
        r_cnt    <= CNT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_enter_resp) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (w_err || w_cur_we) ? 32'h0 : w_rdata_ext;
      end else if ((r_state == ST_RESP) && i_rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_rsp_err   <= 1'b0;
        r_rsp_rdata <= 32'h0;
      end
    end
  end

  // storage write, byte-masked; storage itself is never reset
  always_ff @(posedge i_clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wmask[b]) r_mem[w_word_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_funct3 = 3'b000;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .i_req_funct3 (req_funct3),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_err    (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one complete transaction with Rsp_ready high; checks latency and response
  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [2:0] f3,
                      input logic [31:0] exp_d, input logic exp_e);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_funct3 = f3;
    rsp_ready = 1'b1;
    chk({tag, " req_ready"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    n = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, " latency"}, n, 3);
    chk({tag, " rdata"}, rsp_rdata, exp_d);
    chk({tag, " err"}, {31'h0, rsp_err}, {31'h0, exp_e});
    @(posedge clk);
    @(negedge clk);
    chk({tag, " valid_drop"}, {31'h0, rsp_valid}, 32'h0);
  endtask

  initial begin
    int n;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst rsp_rdata", rsp_rdata, 32'h0);
    chk("rst rsp_err", {31'h0, rsp_err}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst req_ready", {31'h0, req_ready}, 32'h1);

    // word store/load, byte store and lane loads
    xact("SW100", 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
    xact("LW100", 1'b0, 32'h100, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);
    xact("SB101", 1'b1, 32'h101, 32'h00000080, 3'b000, 32'h0, 1'b0);
    xact("LB101", 1'b0, 32'h101, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0);
    xact("LBU101", 1'b0, 32'h101, 32'h0, 3'b100, 32'h00000080, 1'b0);
    xact("LW100b", 1'b0, 32'h100, 32'h0, 3'b010, 32'hDEAD80EF, 1'b0);
`ifdef DMEM_RESP_MISALIGN_TRAP_EN
    xact("LH103", 1'b0, 32'h103, 32'h0, 3'b001, 32'h0, 1'b1);
`else
    xact("LH103", 1'b0, 32'h103, 32'h0, 3'b001, 32'hFFFFDEAD, 1'b0);
`endif
    xact("LHU102", 1'b0, 32'h102, 32'h0, 3'b101, 32'h0000DEAD, 1'b0);

    // out-of-range store must not alias onto word 0
    xact("SW000", 1'b1, 32'h0, 32'h11223344, 3'b010, 32'h0, 1'b0);
    xact("SW1000", 1'b1, 32'h1000, 32'hCAFEF00D, 3'b010, 32'h0, 1'b1);
    xact("LW000", 1'b0, 32'h0, 32'h0, 3'b010, 32'h11223344, 1'b0);

    // illegal funct3
    xact("LW011", 1'b0, 32'h100, 32'h0, 3'b011, 32'h0, 1'b1);
    xact("SBU000", 1'b1, 32'h0, 32'hFFFFFFFF, 3'b100, 32'h0, 1'b1);
    xact("LW000c", 1'b0, 32'h0, 32'h0, 3'b010, 32'h11223344, 1'b0);

    // halfword store into upper lanes
    xact("SW200z", 1'b1, 32'h200, 32'h0, 3'b010, 32'h0, 1'b0);
    xact("SH202", 1'b1, 32'h202, 32'h0000ABCD, 3'b001, 32'h0, 1'b0);
    xact("LW200h", 1'b0, 32'h200, 32'h0, 3'b010, 32'hABCD0000, 1'b0);
    xact("LH202", 1'b0, 32'h202, 32'h0, 3'b001, 32'hFFFFABCD, 1'b0);
    xact("SW200z2", 1'b1, 32'h200, 32'h0, 3'b010, 32'h0, 1'b0);

    // back-pressure: response held, new request ignored
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_funct3 = 3'b010;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("stall reached", {31'h0, rsp_valid}, 32'h1);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h100; req_wdata = 32'h0; req_funct3 = 3'b010;
      end
      if (c == 3) req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("stall rsp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("stall rsp_rdata", rsp_rdata, 32'hDEAD80EF);
      chk("stall req_ready", {31'h0, req_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stall release valid", {31'h0, rsp_valid}, 32'h0);
    chk("stall release ready", {31'h0, req_ready}, 32'h1);
    xact("LW100post", 1'b0, 32'h100, 32'h0, 3'b010, 32'hDEAD80EF, 1'b0);

    // reset during WAIT drops the pending store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h200; req_wdata = 32'h12345678; req_funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("wrst req_ready", {31'h0, req_ready}, 32'h0);
    chk("wrst rsp_valid", {31'h0, rsp_valid}, 32'h0);
    repeat (2) @(negedge clk);
    chk("wrst rsp_rdata", rsp_rdata, 32'h0);
    chk("wrst rsp_err", {31'h0, rsp_err}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("wrst post ready", {31'h0, req_ready}, 32'h1);
    xact("LW200rst", 1'b0, 32'h200, 32'h0, 3'b010, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
